// File: rtl/boot_pkg.sv
// Shared definitions for the UART boot loader: loader and receiver state encodings
// and the bit-period helper used by both the receiver and its transmit counterpart.
package boot_pkg;

  typedef enum logic [2:0] {
    LD_LEN0  = 3'd0,
    LD_LEN1  = 3'd1,
    LD_DATA  = 3'd2,
    LD_WRITE = 3'd3,
    LD_DONE  = 3'd4,
    LD_ERR   = 3'd5
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, start-glitch rejection,
// one-cycle byte_valid or frame_err pulse after the stop-bit sample.
module uart_rx
  import boot_pkg::*;
#(
  parameter int CLK_FREQ  = 48_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int          CPB_I = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam logic [15:0] CPB   = 16'(CPB_I);
  localparam logic [15:0] HALF  = 16'(CPB_I / 2);

  rx_state_t   state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  bit_idx, bit_idx_d;
  logic [7:0]  shreg, shreg_d;
  logic        byte_valid_d, frame_err_d;
  logic        rx_meta, rx_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_s       <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_s       <= rx_meta;
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_idx_d;
      shreg      <= shreg_d;
      byte_valid <= byte_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  assign byte_data = shreg;

  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    bit_idx_d    = bit_idx;
    shreg_d      = shreg;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          state_d = RX_START;
          cnt_d   = '0;
        end
      end
      RX_START: begin
        // Re-check at mid start bit; a line that is high again was only a glitch.
        if (cnt == HALF - 16'd1) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      RX_DATA: begin
        if (cnt == CPB - 16'd1) begin
          cnt_d     = '0;
          shreg_d   = {rx_s, shreg[7:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      RX_STOP: begin
        if (cnt == CPB - 16'd1) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          if (rx_s) byte_valid_d = 1'b1;
          else      frame_err_d  = 1'b1;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_boot_loader.sv
// Receives a length-prefixed program image over UART and writes it into instruction
// RAM word by word, holding the core in reset until the whole image has landed.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int          CLK_FREQ  = 48_000_000,
  parameter int          BAUD_RATE = 115_200,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          MAX_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uartrx,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  output logic        core_rst,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [15:0] MAX_W = 16'(MAX_WORDS);

  logic       byte_valid, frame_err;
  logic [7:0] byte_data;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (uartrx),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  loader_state_t state, state_d;
  logic [15:0]   count, count_d;
  logic [15:0]   word_idx, word_idx_d;
  logic [1:0]    byte_idx, byte_idx_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   din_q, din_d;
  logic [15:0]   len_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LD_LEN0;
      count    <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      addr_q   <= BASE_ADDR;
      din_q    <= '0;
    end else begin
      state    <= state_d;
      count    <= count_d;
      word_idx <= word_idx_d;
      byte_idx <= byte_idx_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  assign len_full = {byte_data, count[7:0]};

  always_comb begin
    state_d    = state;
    count_d    = count;
    word_idx_d = word_idx;
    byte_idx_d = byte_idx;
    addr_d     = addr_q;
    din_d      = din_q;
    case (state)
      LD_LEN0: begin
        if (byte_valid) begin
          count_d[7:0] = byte_data;
          state_d      = LD_LEN1;
        end
      end
      LD_LEN1: begin
        if (byte_valid) begin
          count_d    = len_full;
          word_idx_d = '0;
          byte_idx_d = '0;
          if (len_full == 16'd0)    state_d = LD_DONE;
          else if (len_full > MAX_W) state_d = LD_ERR;
          else                       state_d = LD_DATA;
        end
      end
      LD_DATA: begin
        if (byte_valid) begin
          din_d[8*byte_idx +: 8] = byte_data;
          byte_idx_d             = byte_idx + 2'd1;
          if (byte_idx == 2'd3) begin
            // Address is latched here so it is stable for the whole write cycle.
            addr_d  = BASE_ADDR + {14'd0, word_idx, 2'b00};
            state_d = LD_WRITE;
          end
        end
      end
      LD_WRITE: begin
        word_idx_d = word_idx + 16'd1;
        byte_idx_d = '0;
        state_d    = (word_idx + 16'd1 == count) ? LD_DONE : LD_DATA;
      end
      LD_DONE: ;
      LD_ERR:  ;
      default: state_d = LD_ERR;
    endcase
    // A bad frame anywhere before completion poisons the load.
    if (frame_err && state != LD_DONE) state_d = LD_ERR;
  end

  assign ram_we    = (state == LD_WRITE);
  assign ram_addr  = addr_q;
  assign ram_din   = din_q;
  assign load_done = (state == LD_DONE);
  assign load_err  = (state == LD_ERR);
  assign core_rst  = (state != LD_DONE);

endmodule
